// File: rtl/keypad_time_entry.sv
// keypad_time_entry
//   Sits after the microwave keyboard encoder. Synchronises the encoder's digit code and
//   key-present flag, debounces press and release, and accepts one digit per physical press.
//   Accepted digits shift right-to-left into a 4-digit BCD MM:SS entry register that the
//   countdown timer consumes with a single-cycle take strobe.
//
//   Optional feature: define KEY_BEEP_EN to build the beep pulse generator
//   (BEEP_CYCLES clocks per accepted digit). Without it beep is tied low.
//
// Ports
//   clk          system clock, rising edge
//   clearn       asynchronous active-low reset
//   enablen      active-low entry enable (high: presses tracked, digits discarded)
//   D[3:0]       digit code from encoder, 0-9
//   key_held     encoder key-present flag
//   cancel       synchronous clear of the entry register (level)
//   take         timer consumes the entry (single-cycle strobe)
//   min_tens, min_units, sec_tens, sec_units   BCD entry digits
//   digit_count  digits entered, 0-4
//   time_valid   digit_count != 0
//   key_accept   one-cycle pulse per shifted digit
//   beep         beep pulse (KEY_BEEP_EN only)
module keypad_time_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BEEP_CYCLES     = 1000
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       enablen,
    input  logic [3:0] D,
    input  logic       key_held,
    input  logic       cancel,
    input  logic       take,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [2:0] digit_count,
    output logic       time_valid,
    output logic       key_accept,
    output logic       beep
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StReleaseDb} state_e;

    // Two-flop synchronisers
    logic       key_meta_q, key_s_q;
    logic [3:0] d_meta_q, d_s_q;

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            key_meta_q <= 1'b0;
            key_s_q    <= 1'b0;
            d_meta_q   <= 4'd0;
            d_s_q      <= 4'd0;
        end else begin
            key_meta_q <= key_held;
            key_s_q    <= key_meta_q;
            d_meta_q   <= D;
            d_s_q      <= d_meta_q;
        end
    end

    // Debounce FSM
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      cand_q, cand_d;
    logic            db_done;
    logic            press_done;

    assign db_done = (cnt_q == CntW'(DEBOUNCE_CYCLES));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        press_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (key_s_q) begin
                    state_d = StPressDb;
                    cnt_d   = CntW'(1);
                    cand_d  = d_s_q;
                end
            end
            StPressDb: begin
                if (!key_s_q) begin
                    state_d = StIdle;
                end else if (d_s_q != cand_q) begin
                    // Code changed mid-press: restart the count on the new digit
                    cand_d = d_s_q;
                    cnt_d  = CntW'(1);
                end else if (db_done) begin
                    state_d    = StHeld;
                    press_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHeld: begin
                if (!key_s_q) begin
                    state_d = StReleaseDb;
                    cnt_d   = CntW'(1);
                end
            end
            StReleaseDb: begin
                // A bounce back to pressed returns to HELD without a new accept
                if (key_s_q) begin
                    state_d = StHeld;
                end else if (db_done) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Entry register: cancel > take > accept
    logic [15:0] entry_q, entry_d;
    logic [2:0]  count_q, count_d;
    logic        accept_q, accept_d;
    logic        digit_ok;

    assign digit_ok = press_done && !enablen && (count_q < 3'd4) && (cand_q <= 4'd9);

    always_comb begin
        entry_d  = entry_q;
        count_d  = count_q;
        accept_d = 1'b0;
        if (cancel || (take && (count_q != 3'd0))) begin
            entry_d = 16'd0;
            count_d = 3'd0;
        end else if (digit_ok) begin
            entry_d  = {entry_q[11:0], cand_q};
            count_d  = count_q + 3'd1;
            accept_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            cand_q   <= 4'd0;
            entry_q  <= 16'd0;
            count_q  <= 3'd0;
            accept_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            entry_q  <= entry_d;
            count_q  <= count_d;
            accept_q <= accept_d;
        end
    end

    assign min_tens    = entry_q[15:12];
    assign min_units   = entry_q[11:8];
    assign sec_tens    = entry_q[7:4];
    assign sec_units   = entry_q[3:0];
    assign digit_count = count_q;
    assign time_valid  = (count_q != 3'd0);
    assign key_accept  = accept_q;

`ifdef KEY_BEEP_EN
    localparam int unsigned BeepW = $clog2(BEEP_CYCLES + 1);

    // Loaded on the same edge key_accept rises; a new accept restarts the count
    logic [BeepW-1:0] beep_cnt_q, beep_cnt_d;

    always_comb begin
        beep_cnt_d = beep_cnt_q;
        if (accept_d) begin
            beep_cnt_d = BeepW'(BEEP_CYCLES);
        end else if (beep_cnt_q != '0) begin
            beep_cnt_d = beep_cnt_q - BeepW'(1);
        end
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            beep_cnt_q <= '0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign beep = (beep_cnt_q != '0);
`else
    logic unused_beep_cycles;
    assign unused_beep_cycles = (BEEP_CYCLES != 0);
    assign beep               = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed bench for keypad_time_entry with DEBOUNCE_CYCLES=4, BEEP_CYCLES=10.
module tb_keypad_time_entry;

    localparam int unsigned Db   = 4;
    localparam int unsigned Beep = 10;
`ifdef KEY_BEEP_EN
    localparam int ExpBeep = 10;
`else
    localparam int ExpBeep = 0;
`endif

    logic       clk;
    logic       clearn;
    logic       enablen;
    logic [3:0] D;
    logic       key_held;
    logic       cancel;
    logic       take;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic [2:0] digit_count;
    logic       time_valid;
    logic       key_accept;
    logic       beep;
    logic [15:0] digits;

    int errors = 0;
    int checks = 0;

    assign digits = {min_tens, min_units, sec_tens, sec_units};

    keypad_time_entry #(
        .DEBOUNCE_CYCLES(Db),
        .BEEP_CYCLES    (Beep)
    ) u_dut (
        .clk        (clk),
        .clearn     (clearn),
        .enablen    (enablen),
        .D          (D),
        .key_held   (key_held),
        .cancel     (cancel),
        .take       (take),
        .min_tens   (min_tens),
        .min_units  (min_units),
        .sec_tens   (sec_tens),
        .sec_units  (sec_units),
        .digit_count(digit_count),
        .time_valid (time_valid),
        .key_accept (key_accept),
        .beep       (beep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clean press of one digit, then a clean release; returns accepts seen
    task automatic press(input logic [3:0] dig, output int acc);
        acc      = 0;
        D        = dig;
        key_held = 1'b1;
        repeat (10) begin
            tick();
            if (key_accept) acc++;
        end
        key_held = 1'b0;
        repeat (10) begin
            tick();
            if (key_accept) acc++;
        end
    endtask

    task automatic cancel_pulse();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    initial begin
        int acc;
        int beep_n;
        clearn   = 1'b0;
        enablen  = 1'b0;
        D        = 4'd0;
        key_held = 1'b0;
        cancel   = 1'b0;
        take     = 1'b0;

        // Reset state
        repeat (3) tick();
        check_eq("rst_digits", digits, 16'h0000);
        check_eq("rst_count", 16'(digit_count), 16'd0);
        check_eq("rst_valid", 16'(time_valid), 16'd0);
        check_eq("rst_accept", 16'(key_accept), 16'd0);
        check_eq("rst_beep", 16'(beep), 16'd0);
        clearn = 1'b1;
        tick();

        // Long hold of 5: one accept exactly 6 clocks after the first sampling edge
        D = 4'd5;
        key_held = 1'b1;
        acc = 0;
        repeat (6) begin
            tick();
            if (key_accept) acc++;
        end
        check_eq("lat_early", 16'(acc), 16'd0);
        tick();
        check_eq("lat_pulse", 16'(key_accept), 16'd1);
        check_eq("first_digit", digits, 16'h0005);
        check_eq("first_count", 16'(digit_count), 16'd1);
        check_eq("first_valid", 16'(time_valid), 16'd1);
        beep_n = beep ? 1 : 0;
        acc = 0;
        repeat (13) begin
            tick();
            if (key_accept) acc++;
            if (beep) beep_n++;
        end
        check_eq("hold_single", 16'(acc), 16'd0);
        check_eq("beep_len", 16'(beep_n), 16'(ExpBeep));
        key_held = 1'b0;
        repeat (10) tick();

        // Four digits then a saturating fifth
        cancel_pulse();
        check_eq("cancel_count", 16'(digit_count), 16'd0);
        press(4'd1, acc); check_eq("acc_1", 16'(acc), 16'd1);
        press(4'd2, acc); check_eq("acc_2", 16'(acc), 16'd1);
        press(4'd3, acc); check_eq("acc_3", 16'(acc), 16'd1);
        press(4'd0, acc); check_eq("acc_0", 16'(acc), 16'd1);
        check_eq("four_digits", digits, 16'h1230);
        check_eq("four_count", 16'(digit_count), 16'd4);
        press(4'd7, acc);
        check_eq("sat_accept", 16'(acc), 16'd0);
        check_eq("sat_digits", digits, 16'h1230);
        check_eq("sat_count", 16'(digit_count), 16'd4);

        // Press bounce then steady hold of 8; release bounce gives no second accept
        cancel_pulse();
        D = 4'd8;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            key_held = (i % 2 == 0);
            tick();
            if (key_accept) acc++;
        end
        key_held = 1'b1;
        repeat (10) begin
            tick();
            if (key_accept) acc++;
        end
        check_eq("bounce_press", 16'(acc), 16'd1);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            key_held = (i % 2 == 1);
            tick();
            if (key_accept) acc++;
        end
        repeat (8) begin
            tick();
            if (key_accept) acc++;
        end
        key_held = 1'b0;
        repeat (10) begin
            tick();
            if (key_accept) acc++;
        end
        check_eq("bounce_release", 16'(acc), 16'd0);
        check_eq("bounce_digits", digits, 16'h0008);

        // enablen gating
        enablen = 1'b1;
        press(4'd4, acc);
        check_eq("en_off_accept", 16'(acc), 16'd0);
        check_eq("en_off_digits", digits, 16'h0008);
        enablen = 1'b0;
        press(4'd4, acc);
        check_eq("en_on_accept", 16'(acc), 16'd1);
        check_eq("en_on_digits", digits, 16'h0084);

        // cancel and take coincident with an accept: cancel wins
        cancel_pulse();
        press(4'd4, acc);
        press(4'd5, acc);
        check_eq("pre_cancel", digits, 16'h0045);
        D = 4'd9;
        key_held = 1'b1;
        repeat (6) tick();
        cancel = 1'b1;
        take = 1'b1;
        tick();
        cancel = 1'b0;
        take = 1'b0;
        check_eq("cw_accept", 16'(key_accept), 16'd0);
        check_eq("cw_digits", digits, 16'h0000);
        check_eq("cw_count", 16'(digit_count), 16'd0);
        acc = 0;
        repeat (5) begin
            tick();
            if (key_accept) acc++;
        end
        check_eq("cw_no_reaccept", 16'(acc), 16'd0);
        key_held = 1'b0;
        repeat (10) tick();

        // take with nothing entered is ignored
        take = 1'b1;
        tick();
        take = 1'b0;
        check_eq("take_empty", 16'(digit_count), 16'd0);
        check_eq("take_empty_valid", 16'(time_valid), 16'd0);

        // valid take beats a coincident accept
        press(4'd3, acc);
        check_eq("pre_take", digits, 16'h0003);
        D = 4'd6;
        key_held = 1'b1;
        repeat (6) tick();
        take = 1'b1;
        tick();
        take = 1'b0;
        check_eq("tw_accept", 16'(key_accept), 16'd0);
        check_eq("tw_digits", digits, 16'h0000);
        check_eq("tw_count", 16'(digit_count), 16'd0);
        key_held = 1'b0;
        repeat (10) tick();

        // Reset mid-press: key still held is accepted once after a full debounce
        D = 4'd2;
        key_held = 1'b1;
        repeat (3) tick();
        clearn = 1'b0;
        #2;
        check_eq("mid_rst_count", 16'(digit_count), 16'd0);
        clearn = 1'b1;
        acc = 0;
        repeat (6) begin
            tick();
            if (key_accept) acc++;
        end
        check_eq("mid_rst_early", 16'(acc), 16'd0);
        tick();
        check_eq("mid_rst_pulse", 16'(key_accept), 16'd1);
        check_eq("mid_rst_digits", digits, 16'h0002);
        acc = 0;
        repeat (6) begin
            tick();
            if (key_accept) acc++;
        end
        key_held = 1'b0;
        repeat (10) begin
            tick();
            if (key_accept) acc++;
        end
        check_eq("mid_rst_once", 16'(acc), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
